// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: pipelined immediate extender for the MIPS decode stage.
// Widens an IN_W-bit immediate to OUT_W bits (sign / zero / upper / branch)
// and presents it through a 2-entry skid buffer, so in_ready is a pure
// register output and an ID/EX stall never creates a combinational ready path.
// Optional feature macro: IMM_EXTEND_STATS_EN adds the stat_count accept counter.
module imm_extend_pipe #(
    parameter int IN_W     = 16,
    parameter int OUT_W    = 32,
    parameter int UP_SHIFT = 16,
    parameter int BR_SHIFT = 2,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_neg
`ifdef IMM_EXTEND_STATS_EN
    ,
    output logic [CNT_W-1:0] stat_count
`endif
);

    localparam logic [1:0] MODE_SIGN   = 2'b00;
    localparam logic [1:0] MODE_ZERO   = 2'b01;
    localparam logic [1:0] MODE_UPPER  = 2'b10;
    localparam logic [1:0] MODE_BRANCH = 2'b11;

    // Reject parameter sets the extension logic cannot represent.
    if (IN_W < 1 || IN_W > OUT_W || UP_SHIFT >= OUT_W || BR_SHIFT >= OUT_W || CNT_W < 1) begin : g_param_error
        $error("imm_extend_pipe: illegal parameter combination");
    end

    logic [OUT_W-1:0] sext_word;
    logic [OUT_W-1:0] zext_word;
    logic [OUT_W-1:0] ext_word;

    // Bitwise construction of the sign/zero extended words; with IN_W == OUT_W
    // the upper-bit branch is never generated and the immediate passes through.
    for (genvar gi = 0; gi < OUT_W; gi++) begin : g_ext_bit
        if (gi < IN_W) begin : g_low
            assign sext_word[gi] = in_imm[gi];
            assign zext_word[gi] = in_imm[gi];
        end else begin : g_high
            assign sext_word[gi] = in_imm[IN_W-1];
            assign zext_word[gi] = 1'b0;
        end
    end

    // Mode select: shifts truncate to OUT_W and fill vacated LSBs with zero.
    always_comb begin
        ext_word = sext_word;
        case (in_mode)
            MODE_SIGN:   ext_word = sext_word;
            MODE_ZERO:   ext_word = zext_word;
            MODE_UPPER:  ext_word = zext_word << UP_SHIFT;
            MODE_BRANCH: ext_word = sext_word << BR_SHIFT;
            default:     ext_word = sext_word;
        endcase
    end

    logic             main_valid_reg, main_valid_next;
    logic [OUT_W-1:0] main_data_reg,  main_data_next;
    logic             skid_valid_reg, skid_valid_next;
    logic [OUT_W-1:0] skid_data_reg,  skid_data_next;
    logic             in_ready_reg;
    logic             accept;
    logic             deliver;

    assign accept  = in_valid & in_ready_reg;
    assign deliver = main_valid_reg & out_ready;

    // Skid-buffer next state: main refills from skid first to keep FIFO order;
    // the skid only captures when main is full and held by the consumer.
    always_comb begin
        main_valid_next = main_valid_reg;
        main_data_next  = main_data_reg;
        skid_valid_next = skid_valid_reg;
        skid_data_next  = skid_data_reg;
        if (!main_valid_reg || deliver) begin
            if (skid_valid_reg) begin
                main_valid_next = 1'b1;
                main_data_next  = skid_data_reg;
                skid_valid_next = 1'b0;
            end else if (accept) begin
                main_valid_next = 1'b1;
                main_data_next  = ext_word;
            end else begin
                main_valid_next = 1'b0;
            end
        end else if (accept) begin
            skid_valid_next = 1'b1;
            skid_data_next  = ext_word;
        end
    end

    // State registers; in_ready is registered from the next skid occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid_reg <= 1'b0;
            main_data_reg  <= '0;
            skid_valid_reg <= 1'b0;
            skid_data_reg  <= '0;
            in_ready_reg   <= 1'b1;
        end else begin
            main_valid_reg <= main_valid_next;
            main_data_reg  <= main_data_next;
            skid_valid_reg <= skid_valid_next;
            skid_data_reg  <= skid_data_next;
            in_ready_reg   <= ~skid_valid_next;
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = main_valid_reg;
    assign out_data  = main_data_reg;
    assign out_neg   = main_data_reg[OUT_W-1];

`ifdef IMM_EXTEND_STATS_EN
    logic [CNT_W-1:0] stat_count_reg;

    // Accepted-transfer counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_count_reg <= '0;
        end else if (accept) begin
            stat_count_reg <= stat_count_reg + CNT_W'(1);
        end
    end

    assign stat_count = stat_count_reg;
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Testbench for imm_extend_pipe: directed mode/stall/reset scenarios plus a
// randomized stream checked against a queue-based reference model.
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_imm = '0;
    logic [1:0]  in_mode = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        out_neg;
`ifdef IMM_EXTEND_STATS_EN
    logic [3:0]  stat_count;
`endif

    logic        v8 = 1'b0;
    logic        in_ready8;
    logic [7:0]  imm8 = '0;
    logic [1:0]  mode8 = '0;
    logic        out_valid8;
    logic [15:0] out_data8;
    logic        out_neg8;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    int acc_count = 0;

    always #5 clk = ~clk;

    imm_extend_pipe #(.IN_W(16), .OUT_W(32), .UP_SHIFT(16), .BR_SHIFT(2), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_neg(out_neg)
`ifdef IMM_EXTEND_STATS_EN
        , .stat_count(stat_count)
`endif
    );

    imm_extend_pipe #(.IN_W(8), .OUT_W(16), .UP_SHIFT(8), .BR_SHIFT(2), .CNT_W(4)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(v8), .in_ready(in_ready8), .in_imm(imm8), .in_mode(mode8),
        .out_valid(out_valid8), .out_ready(1'b1), .out_data(out_data8), .out_neg(out_neg8)
`ifdef IMM_EXTEND_STATS_EN
        , .stat_count()
`endif
    );

    // Reference extension from the arithmetic meaning of each mode.
    function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [1:0] mode);
        longint s;
        longint v;
        s = (imm >= 16'h8000) ? longint'(imm) - 65536 : longint'(imm);
        case (mode)
            2'd0:    v = s;
            2'd1:    v = longint'(imm);
            2'd2:    v = longint'(imm) * 65536;
            default: v = s * 4;
        endcase
        return v[31:0];
    endfunction

    // One clock cycle: drive, check the model's view of occupancy, score, advance.
    task automatic cycle(input logic v, input logic [15:0] imm, input logic [1:0] mode, input logic ordy);
        logic acc;
        logic dlv;
        logic [31:0] e;
        in_valid  = v;
        in_imm    = imm;
        in_mode   = mode;
        out_ready = ordy;
        #1;
        checks++;
        if (out_valid !== (exp_q.size() > 0)) begin
            errors++;
            $display("FAIL out_valid: got %b expected %b", out_valid, exp_q.size() > 0);
        end
        checks++;
        if (in_ready !== (exp_q.size() < 2)) begin
            errors++;
            $display("FAIL in_ready: got %b expected %b", in_ready, exp_q.size() < 2);
        end
`ifdef IMM_EXTEND_STATS_EN
        checks++;
        if (stat_count !== 4'(acc_count)) begin
            errors++;
            $display("FAIL stat_count: got %0d expected %0d", stat_count, acc_count % 16);
        end
`endif
        acc = v && (exp_q.size() < 2);
        dlv = ordy && (exp_q.size() > 0);
        if (dlv) begin
            e = exp_q.pop_front();
            checks++;
            if (out_data !== e || out_neg !== e[31]) begin
                errors++;
                $display("FAIL deliver: got %h neg %b expected %h", out_data, out_neg, e);
            end
            $display("deliver data=%h", e);
        end
        if (acc) begin
            exp_q.push_back(ref_ext(imm, mode));
            acc_count++;
            $display("accept imm=%h mode=%0d", imm, mode);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_imm   = 'x;
        in_mode  = 'x;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0 || out_neg !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got v=%b r=%b d=%h n=%b expected 0 1 0 0", out_valid, in_ready, out_data, out_neg);
        end
        rst = 1'b0;
        exp_q.delete();
        acc_count = 0;
    endtask

    task automatic test_modes;
        logic [31:0] want [4];
        want[0] = 32'hFFFF8001;
        want[1] = 32'h00008001;
        want[2] = 32'h80010000;
        want[3] = 32'hFFFE0004;
        for (int m = 0; m < 4; m++) begin
            cycle(1'b1, 16'h8001, 2'(m), 1'b1);
            checks++;
            if (out_valid !== 1'b1 || out_data !== want[m]) begin
                errors++;
                $display("FAIL mode%0d: got v=%b %h expected %h", m, out_valid, out_data, want[m]);
            end
            cycle(1'b0, 16'h0, 2'd0, 1'b1);
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 16'($urandom), 2'($urandom_range(0, 3)), 1'b1);
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL stream%0d: got ready=%b valid=%b expected 1 1", i, in_ready, out_valid);
            end
        end
        cycle(1'b0, 16'h0, 2'd0, 1'b1);
    endtask

    task automatic test_stall;
        cycle(1'b1, 16'h1234, 2'd1, 1'b1);
        cycle(1'b1, 16'h8765, 2'd0, 1'b0);
        checks++;
        if (in_ready !== 1'b0 || out_data !== 32'h00001234) begin
            errors++;
            $display("FAIL stall: got ready=%b data=%h expected 0 00001234", in_ready, out_data);
        end
        cycle(1'b1, 16'h5555, 2'd0, 1'b0);
        checks++;
        if (out_data !== 32'h00001234) begin
            errors++;
            $display("FAIL stall_hold: got %h expected 00001234", out_data);
        end
        cycle(1'b0, 16'h0, 2'd0, 1'b1);
        checks++;
        if (in_ready !== 1'b1 || out_data !== 32'hFFFF8765) begin
            errors++;
            $display("FAIL skid_drain: got ready=%b data=%h expected 1 ffff8765", in_ready, out_data);
        end
        cycle(1'b0, 16'h0, 2'd0, 1'b1);
        cycle(1'b0, 16'h0, 2'd0, 1'b1);
    endtask

    task automatic test_random;
        for (int i = 0; i < 300; i++)
            cycle(1'($urandom_range(0, 1)), 16'($urandom), 2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0));
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 16'h0, 2'd0, 1'b1);
    endtask

    task automatic test_reset_mid;
        cycle(1'b1, 16'hAAAA, 2'd0, 1'b0);
        cycle(1'b1, 16'hBBBB, 2'd1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid: got v=%b r=%b d=%h expected 0 1 0", out_valid, in_ready, out_data);
        end
        exp_q.delete();
        acc_count = 0;
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 16'h0, 2'd0, 1'b1);
    endtask

    task automatic test_width;
        logic [15:0] want [2];
        want[0] = 16'hFFF0;
        want[1] = 16'h00F0;
        for (int m = 0; m < 2; m++) begin
            v8 = 1'b1;
            imm8 = 8'hF0;
            mode8 = 2'(m);
            @(posedge clk);
            #1;
            v8 = 1'b0;
            checks++;
            if (out_valid8 !== 1'b1 || out_data8 !== want[m] || out_neg8 !== want[m][15]) begin
                errors++;
                $display("FAIL width8_mode%0d: got v=%b %h expected %h", m, out_valid8, out_data8, want[m]);
            end
            $display("width8 mode=%0d data=%h", m, out_data8);
        end
    endtask

`ifdef IMM_EXTEND_STATS_EN
    task automatic test_stats;
        rst = 1'b1;
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        acc_count = 0;
        for (int i = 0; i < 17; i++) begin
            cycle(1'b1, 16'($urandom), 2'd0, 1'b1);
            if (i == 5) begin
                cycle(1'b1, 16'h1, 2'd0, 1'b0);
                cycle(1'b1, 16'h2, 2'd0, 1'b0);
                cycle(1'b1, 16'h3, 2'd0, 1'b0);
                cycle(1'b0, 16'h0, 2'd0, 1'b1);
                cycle(1'b0, 16'h0, 2'd0, 1'b1);
            end
        end
        checks++;
        if (stat_count !== 4'(acc_count)) begin
            errors++;
            $display("FAIL stat_wrap: got %0d expected %0d", stat_count, acc_count % 16);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_modes();
        test_back_to_back();
        test_stall();
        test_random();
        test_reset_mid();
        test_width();
`ifdef IMM_EXTEND_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
